// File: rtl/memlcd_rx.sv
// memlcd_rx: receiver/decoder for the memory-LCD serial stream (scs/sclk/si).
// Synchronises the three async lines into clk, parses mode/address/data/header
// fields LSB-first and emits pixel bytes, line/frame events and protocol errors.
// Ports:
//   clk, rst_n                  system clock, synchronous active-low reset
//   lcd_scs, lcd_sclk, lcd_si   async serial bus (select, clock, data)
//   px_valid/px_line/px_byte/px_data   one-cycle pixel byte strobe and payload
//   line_done, frame_done       one-cycle line / frame completion pulses
//   vcom                        last M1 value received
//   clear_pulse                 one-cycle pulse on a completed mode with M2=1
//   err_abort/err_range/err_overrun    one-cycle protocol error pulses
module memlcd_rx #(
   parameter int unsigned WIDTH       = 336,
   parameter int unsigned LINES       = 536,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       lcd_scs,
   input  logic       lcd_sclk,
   input  logic       lcd_si,
   output logic       px_valid,
   output logic [9:0] px_line,
   output logic [5:0] px_byte,
   output logic [7:0] px_data,
   output logic       line_done,
   output logic       frame_done,
   output logic       vcom,
   output logic       clear_pulse,
   output logic       err_abort,
   output logic       err_range,
   output logic       err_overrun
);

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned BYTE_W = 6;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned MODE_N = 6;
   localparam int unsigned HDR_N  = 16;
   localparam int unsigned HIST_W = ADDR_W - 1;
   localparam int unsigned BIT_W  = $clog2(WIDTH + HDR_N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MODE,
      S_ADDR,
      S_DATA,
      S_HDR,
      S_TRAIL,
      S_SKIP
   } state_t;

   // Synchronisers and edge history; left free-running through reset so a
   // select already high at reset release is not mistaken for a new frame.
   logic [SYNC_STAGES-1:0] scs_sync_q;
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] si_sync_q;
   logic                   scs_prev_q;
   logic                   sclk_prev_q;

   always_ff @(posedge clk) begin
      scs_sync_q  <= {scs_sync_q[SYNC_STAGES-2:0], lcd_scs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], lcd_sclk};
      si_sync_q   <= {si_sync_q[SYNC_STAGES-2:0], lcd_si};
      scs_prev_q  <= scs_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
   end

   logic scs_s;
   logic si_s;
   logic scs_rise;
   logic scs_fall;
   logic sclk_rise;

   assign scs_s     = scs_sync_q[SYNC_STAGES-1];
   assign si_s      = si_sync_q[SYNC_STAGES-1];
   assign scs_rise  = scs_s & ~scs_prev_q;
   assign scs_fall  = ~scs_s & scs_prev_q;
   assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;

   // Decoder state and registered outputs
   state_t              state_q,      state_d;
   logic [HIST_W-1:0]   hist_q,       hist_d;
   logic [BIT_W-1:0]    bit_cnt_q,    bit_cnt_d;
   logic [BYTE_W-1:0]   byte_cnt_q,   byte_cnt_d;
   logic                px_valid_q,   px_valid_d;
   logic [ADDR_W-1:0]   px_line_q,    px_line_d;
   logic [BYTE_W-1:0]   px_byte_q,    px_byte_d;
   logic [DATA_W-1:0]   px_data_q,    px_data_d;
   logic                line_done_q,  line_done_d;
   logic                frame_done_q, frame_done_d;
   logic                vcom_q,       vcom_d;
   logic                clear_q,      clear_d;
   logic                abort_q,      abort_d;
   logic                range_q,      range_d;
   logic                overrun_q,    overrun_d;

   // History holds the previous 9 bits, newest at the MSB; combined with the
   // current bit it yields any completed field without a wider shifter.
   logic [ADDR_W-1:0] field_addr;
   logic [DATA_W-1:0] field_byte;
   logic              addr_bad;

   assign field_addr = {si_s, hist_q};
   assign field_byte = {si_s, hist_q[HIST_W-1 -: DATA_W-1]};
   assign addr_bad   = (field_addr > ADDR_W'(LINES));

   // Next-state and output decode
   always_comb begin
      state_d      = state_q;
      hist_d       = hist_q;
      bit_cnt_d    = bit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      px_valid_d   = 1'b0;
      px_line_d    = px_line_q;
      px_byte_d    = px_byte_q;
      px_data_d    = px_data_q;
      line_done_d  = 1'b0;
      frame_done_d = 1'b0;
      vcom_d       = vcom_q;
      clear_d      = 1'b0;
      abort_d      = 1'b0;
      range_d      = 1'b0;
      overrun_d    = 1'b0;

      if (scs_fall) begin
         // A select fall wins over a coincident sclk rise.
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
         state_d    = S_IDLE;
         case (state_q)
            S_MODE, S_ADDR, S_DATA, S_HDR: abort_d      = 1'b1;
            S_TRAIL:                       frame_done_d = 1'b1;
            default:                       ;
         endcase
      end else if (state_q == S_IDLE) begin
         if (scs_rise) begin
            state_d    = S_MODE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
         end
      end else if (sclk_rise && scs_s) begin
         hist_d    = {si_s, hist_q[HIST_W-1:1]};
         bit_cnt_d = bit_cnt_q + BIT_W'(1);
         case (state_q)
            S_MODE: begin
               if (bit_cnt_q == BIT_W'(MODE_N - 1)) begin
                  // M0..M2 sit at history bits 4..6 once the 6th bit arrives
                  vcom_d    = hist_q[5];
                  clear_d   = hist_q[6];
                  bit_cnt_d = '0;
                  state_d   = hist_q[4] ? S_ADDR : S_SKIP;
               end
            end
            S_ADDR: begin
               if (bit_cnt_q == BIT_W'(ADDR_W - 1)) begin
                  bit_cnt_d = '0;
                  if (field_addr == '0 || addr_bad) begin
                     range_d = 1'b1;
                     state_d = S_SKIP;
                  end else begin
                     px_line_d  = field_addr;
                     byte_cnt_d = '0;
                     state_d    = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (bit_cnt_q[2:0] == 3'd7) begin
                  px_valid_d = 1'b1;
                  px_data_d  = field_byte;
                  px_byte_d  = byte_cnt_q;
                  byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                  if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                     line_done_d = 1'b1;
                     byte_cnt_d  = '0;
                     bit_cnt_d   = '0;
                     state_d     = S_HDR;
                  end
               end
            end
            S_HDR: begin
               if (bit_cnt_q == BIT_W'(HDR_N - 1)) begin
                  bit_cnt_d = '0;
                  if (field_addr == '0) begin
                     state_d = S_TRAIL;
                  end else if (addr_bad) begin
                     range_d = 1'b1;
                     state_d = S_SKIP;
                  end else begin
                     px_line_d  = field_addr;
                     byte_cnt_d = '0;
                     state_d    = S_DATA;
                  end
               end
            end
            S_TRAIL: begin
               overrun_d = 1'b1;
               bit_cnt_d = '0;
               state_d   = S_SKIP;
            end
            default: begin
               bit_cnt_d = bit_cnt_q;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         hist_q       <= '0;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         px_valid_q   <= 1'b0;
         px_line_q    <= '0;
         px_byte_q    <= '0;
         px_data_q    <= '0;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         vcom_q       <= 1'b0;
         clear_q      <= 1'b0;
         abort_q      <= 1'b0;
         range_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hist_q       <= hist_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         px_valid_q   <= px_valid_d;
         px_line_q    <= px_line_d;
         px_byte_q    <= px_byte_d;
         px_data_q    <= px_data_d;
         line_done_q  <= line_done_d;
         frame_done_q <= frame_done_d;
         vcom_q       <= vcom_d;
         clear_q      <= clear_d;
         abort_q      <= abort_d;
         range_q      <= range_d;
         overrun_q    <= overrun_d;
      end
   end

   assign px_valid    = px_valid_q;
   assign px_line     = px_line_q;
   assign px_byte     = px_byte_q;
   assign px_data     = px_data_q;
   assign line_done   = line_done_q;
   assign frame_done  = frame_done_q;
   assign vcom        = vcom_q;
   assign clear_pulse = clear_q;
   assign err_abort   = abort_q;
   assign err_range   = range_q;
   assign err_overrun = overrun_q;

endmodule

// File: tb/tb_memlcd_rx.sv
// tb_memlcd_rx: directed and randomized frames for memlcd_rx, checked against
// a transaction-level model of the expected pixel bytes and event pulses.
module tb_memlcd_rx;

   localparam int WIDTH = 336;
   localparam int BPL   = WIDTH / 8;
   localparam int LINES = 536;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       lcd_scs = 1'b0;
   logic       lcd_sclk = 1'b0;
   logic       lcd_si = 1'b0;
   logic       px_valid;
   logic [9:0] px_line;
   logic [5:0] px_byte;
   logic [7:0] px_data;
   logic       line_done;
   logic       frame_done;
   logic       vcom;
   logic       clear_pulse;
   logic       err_abort;
   logic       err_range;
   logic       err_overrun;

   memlcd_rx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lcd_scs    (lcd_scs),
      .lcd_sclk   (lcd_sclk),
      .lcd_si     (lcd_si),
      .px_valid   (px_valid),
      .px_line    (px_line),
      .px_byte    (px_byte),
      .px_data    (px_data),
      .line_done  (line_done),
      .frame_done (frame_done),
      .vcom       (vcom),
      .clear_pulse(clear_pulse),
      .err_abort  (err_abort),
      .err_range  (err_range),
      .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // transaction description: line addresses and their bytes
   int         t_addr [3];
   logic [7:0] t_data [3][BPL];

   // expected results
   logic [23:0] exp_px [$];
   int e_ld, e_fd, e_clr, e_ab, e_rg, e_ov;
   logic m_vcom = 1'b0;

   // observed results
   logic [23:0] got_px [$];
   int g_ld = 0, g_fd = 0, g_clr = 0, g_ab = 0, g_rg = 0, g_ov = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (px_valid)    got_px.push_back({px_line, px_byte, px_data});
         if (line_done)   g_ld++;
         if (frame_done)  g_fd++;
         if (clear_pulse) g_clr++;
         if (err_abort)   g_ab++;
         if (err_range)   g_rg++;
         if (err_overrun) g_ov++;
      end
   end

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic clear_exp();
      e_ld = 0; e_fd = 0; e_clr = 0; e_ab = 0; e_rg = 0; e_ov = 0;
      exp_px.delete();
   endtask

   task automatic check_frame(input string tag);
      chk({tag, "/px_cnt"}, got_px.size(), exp_px.size());
      for (int i = 0; i < exp_px.size() && i < got_px.size(); i++)
         chk({tag, "/px"}, int'(got_px[i]), int'(exp_px[i]));
      chk({tag, "/line_done"},   g_ld,  e_ld);
      chk({tag, "/frame_done"},  g_fd,  e_fd);
      chk({tag, "/clear_pulse"}, g_clr, e_clr);
      chk({tag, "/err_abort"},   g_ab,  e_ab);
      chk({tag, "/err_range"},   g_rg,  e_rg);
      chk({tag, "/err_overrun"}, g_ov,  e_ov);
      chk({tag, "/vcom"}, int'(vcom), int'(m_vcom));
      got_px.delete();
      g_ld = 0; g_fd = 0; g_clr = 0; g_ab = 0; g_rg = 0; g_ov = 0;
   endtask

   task automatic send_bit(input logic b);
      lcd_si = b;
      repeat (4) @(posedge clk);
      lcd_sclk = 1'b1;
      repeat (4) @(posedge clk);
      lcd_sclk = 1'b0;
   endtask

   // Build one scs window from the description, derive the expected outcome
   // from the framing rules, drive it and compare. cut>=0 truncates the bits.
   task automatic run_frame(input string tag, input logic [5:0] mode, input int nl,
                            input int cut, input int extra);
      logic bq [$];
      int   nbits, pos;
      bit   stop, skipped;
      for (int i = 0; i < 6; i++) bq.push_back(mode[i]);
      if (mode[0]) begin
         for (int k = 0; k < nl; k++) begin
            if (k > 0) for (int i = 0; i < 6; i++) bq.push_back(1'($urandom));
            for (int i = 0; i < 10; i++) bq.push_back(t_addr[k][i]);
            for (int j = 0; j < BPL; j++)
               for (int i = 0; i < 8; i++) bq.push_back(t_data[k][j][i]);
         end
         for (int i = 0; i < 6; i++) bq.push_back(1'($urandom));
         for (int i = 0; i < 10; i++) bq.push_back(1'b0);
         for (int i = 0; i < extra; i++) bq.push_back(1'($urandom));
      end else begin
         for (int i = 0; i < 16; i++) bq.push_back(1'($urandom));
      end
      nbits = (cut >= 0) ? cut : bq.size();

      clear_exp();
      if (nbits < 6) begin
         e_ab = 1;
      end else begin
         m_vcom = mode[1];
         e_clr  = int'(mode[2]);
         if (mode[0]) begin
            pos = 6; stop = 0; skipped = 0;
            for (int k = 0; k < nl; k++) begin
               if (k > 0) pos += 6;
               if (pos + 10 > nbits) begin stop = 1; break; end
               if (t_addr[k] == 0 || t_addr[k] > LINES) begin
                  e_rg = 1; skipped = 1; break;
               end
               pos += 10;
               for (int j = 0; j < BPL; j++)
                  if (pos + 8 * j + 8 <= nbits)
                     exp_px.push_back({10'(t_addr[k]), 6'(j), t_data[k][j]});
               if (pos + WIDTH > nbits) begin stop = 1; break; end
               e_ld++;
               pos += WIDTH;
            end
            if (!skipped) begin
               if (!stop && pos + 16 <= nbits) begin
                  if (nbits > pos + 16) e_ov = 1;
                  else                  e_fd = 1;
               end else begin
                  e_ab = 1;
               end
            end
         end
      end

      lcd_scs = 1'b1;
      repeat (4) @(posedge clk);
      for (int i = 0; i < nbits; i++) send_bit(bq[i]);
      repeat (4) @(posedge clk);
      lcd_scs = 1'b0;
      repeat (10) @(posedge clk);
      check_frame(tag);
   endtask

   initial begin
      int nl;
      logic [5:0] md;

      // reset with an active-looking bus
      lcd_scs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         lcd_sclk = ~lcd_sclk;
      end
      @(negedge clk);
      chk("reset/outputs",
          int'({px_valid, px_line, px_byte, px_data, line_done, frame_done, vcom,
                clear_pulse, err_abort, err_range, err_overrun}), 0);
      @(posedge clk);
      rst_n = 1'b1;
      lcd_scs = 1'b0;
      lcd_sclk = 1'b0;
      repeat (20) @(posedge clk);
      clear_exp();
      check_frame("idle");

      // single line, address 5, bytes 0..41
      t_addr[0] = 5;
      for (int j = 0; j < BPL; j++) t_data[0][j] = 8'(j);
      run_frame("single", 6'b000001, 1, -1, 0);

      // three lines back-to-back including the last valid address
      t_addr[0] = 1; t_addr[1] = 2; t_addr[2] = LINES;
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < BPL; j++) t_data[k][j] = 8'hA5;
      run_frame("multi", 6'b000001, 3, -1, 0);

      // mode only: vcom and clear, no data
      run_frame("mode_only", 6'b000110, 0, -1, 0);

      // reset mid-transaction: partial line discarded, vcom back to 0
      lcd_scs = 1'b1;
      repeat (4) @(posedge clk);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
      for (int i = 0; i < 10; i++) send_bit(i == 0 || i == 3);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst_n = 1'b0;
      repeat (4) @(posedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      lcd_scs = 1'b0;
      repeat (10) @(posedge clk);
      clear_exp();
      m_vcom = 1'b0;
      check_frame("rst_mid");

      // abort after 20 data bits, then a clean frame for address 8
      t_addr[0] = 7;
      for (int j = 0; j < BPL; j++) t_data[0][j] = 8'($urandom);
      run_frame("abort", 6'b000001, 1, 6 + 10 + 20, 0);
      t_addr[0] = 8;
      for (int j = 0; j < BPL; j++) t_data[0][j] = 8'(j);
      run_frame("after_abort", 6'b000001, 1, -1, 0);

      // range errors: address above LINES and zero first address
      t_addr[0] = LINES + 1;
      run_frame("range_hi", 6'b000001, 1, 40, 0);
      t_addr[0] = 0;
      run_frame("range_zero", 6'b000011, 1, 40, 0);

      // overrun: one bit after the zero trailer
      t_addr[0] = 3;
      for (int j = 0; j < BPL; j++) t_data[0][j] = 8'($urandom);
      run_frame("overrun", 6'b000001, 1, -1, 1);

      // randomized frames
      for (int r = 0; r < 3; r++) begin
         nl = 1 + (r % 2);
         for (int k = 0; k < nl; k++) begin
            t_addr[k] = int'($urandom_range(LINES, 1));
            for (int j = 0; j < BPL; j++) t_data[k][j] = 8'($urandom);
         end
         md = {5'($urandom), 1'b1};
         run_frame("rand", md, nl, -1, 0);
      end
      md = {5'($urandom), 1'b0};
      run_frame("rand_m0", md, 0, -1, 0);

      // random truncation anywhere inside a one-line frame
      t_addr[0] = int'($urandom_range(LINES, 1));
      for (int j = 0; j < BPL; j++) t_data[0][j] = 8'($urandom);
      run_frame("rand_cut", 6'b000001, 1, int'($urandom_range(6 + 10 + WIDTH + 15, 1)), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
